// File: rtl/fetch_redirect.sv
// rtl/fetch_redirect.sv - PC register, fetch request and branch/jump redirect with flush shadow
module fetch_redirect #(
    parameter int            n            = 32,
    parameter logic [n-1:0]  RESET_PC     = '0,
    parameter int            FLUSH_CYCLES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         imem_ready,
    input  logic         ex_valid,
    input  logic         ex_isbr,
    input  logic         ex_jump,
    input  logic         brnch,
    input  logic [n-1:0] ex_target,
    output logic [n-1:0] pc,
    output logic         imem_req,
    output logic         flush,
    output logic         exc_misalign,
    output logic         halted
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Shadow counter is loaded with one less than the flush length so that
    // reaching zero marks the last flushed cycle.
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       taken;
    logic       misaligned;
    logic       advance;

    // Redirect decision and sequential-fetch advance condition.
    always_comb begin
        taken      = ex_valid & ((ex_isbr & brnch) | ex_jump);
        misaligned = |ex_target[1:0];
        advance    = ~stall & imem_ready;
    end

    // Fetch request is dropped in HALT and while reset is held.
    always_comb begin
        imem_req = ~reset & (state != HALT);
        halted   = (state == HALT);
    end

    // PC, redirect/flush sequencing and trap handling.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            pc           <= RESET_PC;
            flush        <= 1'b0;
            exc_misalign <= 1'b0;
            cnt          <= 3'd0;
        end else begin
            exc_misalign <= 1'b0;
            case (state)
                RUN: begin
                    if (taken && misaligned) begin
                        // Trap: pc stays on the fetch that was in flight.
                        exc_misalign <= 1'b1;
                        flush        <= 1'b0;
                        state        <= HALT;
                    end else if (taken) begin
                        // Redirect overrides stall and an unaccepted fetch.
                        pc    <= ex_target;
                        flush <= 1'b1;
                        cnt   <= CNT_INIT;
                        state <= FLUSH;
                    end else if (advance) begin
                        pc <= pc + n'(4);
                    end
                end
                FLUSH: begin
                    // Branches seen here are wrong-path and are ignored.
                    if (advance) begin
                        pc <= pc + n'(4);
                    end
                    if (cnt == 3'd0) begin
                        flush <= 1'b0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                HALT: begin
                    flush <= 1'b0;
                end
                default: begin
                    flush <= 1'b0;
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_redirect.sv
// tb/tb_fetch_redirect.sv - self-checking bench for fetch_redirect with a reference model
module tb_fetch_redirect;

    localparam int          FC       = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic        ex_valid;
    logic        ex_isbr;
    logic        ex_jump;
    logic        brnch;
    logic [31:0] ex_target;
    logic [31:0] pc;
    logic        imem_req;
    logic        flush;
    logic        exc_misalign;
    logic        halted;

    int checks_done;
    int checks_failed;

    // Reference model: remaining flush cycles, halted flag, pending trap pulse.
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_halt;
    bit          m_exc;

    fetch_redirect #(
        .n            (32),
        .RESET_PC     (RST_PC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .ex_valid     (ex_valid),
        .ex_isbr      (ex_isbr),
        .ex_jump      (ex_jump),
        .brnch        (brnch),
        .ex_target    (ex_target),
        .pc           (pc),
        .imem_req     (imem_req),
        .flush        (flush),
        .exc_misalign (exc_misalign),
        .halted       (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_done++;
        if (obs !== exp) begin
            checks_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the currently applied inputs.
    task automatic model_step();
        bit t;
        bit in_flush;
        if (reset) begin
            m_pc         = RST_PC;
            m_flush_left = 0;
            m_halt       = 0;
            m_exc        = 0;
        end else if (m_halt) begin
            m_exc = 0;
        end else begin
            t        = ex_valid && ((ex_isbr && brnch) || ex_jump);
            in_flush = (m_flush_left > 0);
            m_exc    = 0;
            if (!in_flush && t && (ex_target % 4 != 0)) begin
                m_exc  = 1;
                m_halt = 1;
                m_flush_left = 0;
            end else if (!in_flush && t) begin
                m_pc         = ex_target;
                m_flush_left = FC;
            end else begin
                if (!stall && imem_ready) m_pc = m_pc + 32'd4;
                if (in_flush) m_flush_left = m_flush_left - 1;
            end
        end
    endtask

    // One clock: update model at the edge, compare every output on the falling edge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("pc",           64'(pc),           64'(m_pc));
        check("flush",        64'(flush),        64'(m_flush_left > 0));
        check("exc_misalign", 64'(exc_misalign), 64'(m_exc));
        check("halted",       64'(halted),       64'(m_halt));
        check("imem_req",     64'(imem_req),     64'(!reset && !m_halt));
    endtask

    task automatic idle_branch();
        ex_valid = 0; ex_isbr = 0; ex_jump = 0; brnch = 0;
    endtask

    logic [31:0] held_pc;

    initial begin
        checks_done   = 0;
        checks_failed = 0;
        m_pc = '0; m_flush_left = 0; m_halt = 0; m_exc = 0;
        reset = 1; stall = 0; imem_ready = 0; ex_target = '0;
        idle_branch();

        // Reset state
        @(negedge clock);
        cycle();
        cycle();
        check("reset_imem_req", 64'(imem_req), 64'd0);
        check("reset_pc", 64'(pc), 64'(RST_PC));

        // Sequential fetch
        reset = 0; imem_ready = 1;
        repeat (4) cycle();
        check("seq_pc_0x10", 64'(pc), 64'h10);
        check("seq_imem_req", 64'(imem_req), 64'd1);

        // Stall holds, then resume; not-ready holds
        stall = 1;
        repeat (3) cycle();
        check("stall_hold", 64'(pc), 64'h10);
        stall = 0;
        cycle();
        check("stall_resume", 64'(pc), 64'h14);
        imem_ready = 0;
        repeat (2) cycle();
        check("notready_hold", 64'(pc), 64'h14);
        imem_ready = 1;

        // Taken branch under stall, second taken inside the shadow ignored
        ex_valid = 1; ex_isbr = 1; brnch = 1; ex_target = 32'h100; stall = 1;
        cycle();
        check("redirect_pc", 64'(pc), 64'h100);
        check("redirect_flush", 64'(flush), 64'd1);
        stall = 0; ex_target = 32'h200;
        cycle();
        check("shadow_pc1", 64'(pc), 64'h104);
        check("shadow_flush2", 64'(flush), 64'd1);
        cycle();
        check("shadow_pc2", 64'(pc), 64'h108);
        check("shadow_flush_end", 64'(flush), 64'd0);

        // Not-taken branch, then unconditional jump
        brnch = 0; ex_target = 32'h100;
        cycle();
        check("nottaken_pc", 64'(pc), 64'h10C);
        ex_isbr = 0; ex_jump = 1; ex_target = 32'h40;
        cycle();
        check("jump_pc", 64'(pc), 64'h40);
        idle_branch();
        repeat (2) cycle();

        // Misaligned target traps into HALT
        held_pc = pc;
        ex_valid = 1; ex_jump = 1; ex_target = 32'h102;
        cycle();
        check("mis_exc", 64'(exc_misalign), 64'd1);
        check("mis_halted", 64'(halted), 64'd1);
        check("mis_req", 64'(imem_req), 64'd0);
        check("mis_pc", 64'(pc), 64'(held_pc));
        ex_target = 32'h300;
        cycle();
        check("mis_exc_pulse", 64'(exc_misalign), 64'd0);
        repeat (3) cycle();
        check("halt_frozen", 64'(pc), 64'(held_pc));
        reset = 1;
        cycle();
        check("halt_reset_pc", 64'(pc), 64'(RST_PC));
        check("halt_reset_halted", 64'(halted), 64'd0);
        reset = 0;
        idle_branch();
        cycle();

        // PC wrap-around
        ex_valid = 1; ex_jump = 1; ex_target = 32'hFFFF_FFF8;
        cycle();
        idle_branch();
        cycle();
        check("wrap_fffc", 64'(pc), 64'hFFFF_FFFC);
        cycle();
        check("wrap_zero", 64'(pc), 64'h0);

        // Reset in the middle of a flush shadow
        repeat (2) cycle();
        ex_valid = 1; ex_jump = 1; ex_target = 32'h80;
        cycle();
        idle_branch();
        reset = 1;
        cycle();
        check("midflush_flush", 64'(flush), 64'd0);
        check("midflush_pc", 64'(pc), 64'(RST_PC));
        reset = 0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            ex_valid   = ($urandom_range(0, 2) == 0);
            ex_isbr    = $urandom_range(0, 1) == 1;
            ex_jump    = ($urandom_range(0, 5) == 0);
            brnch      = $urandom_range(0, 1) == 1;
            ex_target  = $urandom;
            if ($urandom_range(0, 15) != 0) ex_target[1:0] = 2'b00;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule

// File: doc/fetch_redirect.md
Name: fetch_redirect

Overview:
- Program-counter and fetch-redirect unit for the RISC-V core. It is the consumer of the branch-condition signal `brnch` produced in execute.
- Holds the PC and issues fetch requests to instruction memory.
- On a taken branch or jump it loads the target PC and flushes the wrong-path instructions behind the branch for a fixed shadow window.
- A misaligned target traps into a halted state.

Parameters:
- n, 32, datapath/PC width in bits
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FLUSH_CYCLES, 2, cycles flush stays asserted after a redirect (number of younger pipeline stages); legal range 1..7

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard unit hold; PC must not advance
- imem_ready  input  1  instruction memory accepts the current fetch this cycle
- ex_valid  input  1  execute-stage instruction is valid
- ex_isbr  input  1  execute instruction is a conditional branch
- ex_jump  input  1  execute instruction is JAL/JALR (unconditional)
- brnch  input  1  branch condition result from the execute stage
- ex_target  input  n  computed branch/jump target address
- pc  output  n  current fetch address
- imem_req  output  1  fetch request valid
- flush  output  1  kill IF/ID contents (registered)
- exc_misalign  output  1  one-cycle pulse: instruction-address-misaligned trap
- halted  output  1  unit is in HALT state

Behaviour:
- Clock/reset:
  - One clock (`clock`). Reset is synchronous and active-high (`reset`).
  - While `reset`=1 at a clock edge, the next state is: pc=RESET_PC, state=RUN, flush=0, exc_misalign=0, halted=0, shadow counter=0.
  - imem_req is 0 while `reset` is high. From the first cycle after reset it is 1 (RUN).
- States: RUN, FLUSH, HALT.
- taken = ex_valid & ((ex_isbr & brnch) | ex_jump). taken is evaluated only in RUN; it is ignored in FLUSH (wrong-path shadow) and in HALT.
- RUN:
  - imem_req=1.
  - Priority order:
    1. taken with ex_target[1:0]!=0: pc holds; exc_misalign=1 for the next cycle only; next state HALT.
    2. taken with aligned target: pc<=ex_target; flush<=1; counter<=FLUSH_CYCLES-1; next state FLUSH. taken overrides stall and a not-ready imem; the outstanding fetch is abandoned.
    3. stall=1: pc holds.
    4. imem_ready=1: pc<=pc+4, modulo 2^n (0xFFFF_FFFC -> 0x0000_0000, no flag).
    5. Otherwise pc holds; imem_req stays high with a stable pc.
- FLUSH:
  - flush=1 and imem_req=1.
  - pc advances by the same stall/imem_ready rules as RUN, from the target.
  - The counter decrements every cycle, independent of stall and ready.
  - When counter=0: flush<=0 and next state RUN.
  - With FLUSH_CYCLES=N, flush is high for exactly N consecutive cycles, starting the cycle after the taken edge.
- HALT:
  - imem_req=0, halted=1, flush=0, pc frozen.
  - Exit is by reset only.
- Latency: redirect is 1 cycle; pc equals ex_target in the cycle after taken is sampled.
- Simultaneous events:
  - taken+stall: redirect wins.
  - reset+taken: reset wins.
  - Reset mid-FLUSH or in HALT returns to RUN at RESET_PC, with flush and halted cleared the same edge.
- All outputs are registered except imem_req and halted, which are decoded from state.

Test Plan:
- Reset, then imem_ready=1, stall=0 for 4 cycles -> imem_req=1 after reset; pc = 0x0, 0x4, 0x8, 0xC, 0x10.
- At pc=0x10, stall=1 for 3 cycles with imem_ready=1 -> pc stays 0x10; then resumes at 0x14. Separately, imem_ready=0 -> pc holds.
- ex_valid=1, ex_isbr=1, brnch=1, ex_target=0x100 with stall=1 -> next cycle pc=0x100 and flush=1 for exactly 2 cycles. A second taken (target 0x200) during FLUSH is ignored; pc continues 0x104, 0x108.
- ex_isbr=1, brnch=0, ex_target=0x100 -> no redirect, flush=0, pc increments normally. ex_jump=1 with brnch=0 and target 0x40 -> redirect to 0x40.
- taken with ex_target=0x102 -> exc_misalign=1 for one cycle, halted=1, imem_req=0, pc unchanged. Further branches and imem_ready have no effect until reset; after reset pc=RESET_PC and halted=0.
- Force pc=0xFFFF_FFF8 via jump, imem_ready=1 -> pc goes 0xFFFF_FFFC then 0x0000_0000. Assert reset mid-FLUSH -> flush=0 and pc=RESET_PC on the next cycle.
